// File: rtl/eros_pkg.sv
// Shared types and default constants for the TMR recovery controller.
//   tmr_rec_state_e    : recovery sequencer states
//   TMR_NHARTS         : number of redundant harts (only 3 supported)
//   TMR_PERM_THRESHOLD : default permanent-fault count threshold
//   TMR_TIMEOUT_CYCLES : default handshake timeout in cycles
//   tmr_is_multi()     : true when more than one hart bit is set
package eros_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StRecover,
    StResume,
    StFatal
  } tmr_rec_state_e;

  localparam int unsigned TMR_NHARTS         = 3;
  localparam int unsigned TMR_PERM_THRESHOLD = 4;
  localparam int unsigned TMR_TIMEOUT_CYCLES = 1024;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic tmr_is_multi(input logic [TMR_NHARTS-1:0] v);
    return (v & (v - TMR_NHARTS'(1))) != '0;
  endfunction

endpackage

// File: rtl/tmr_err_counter.sv
// Saturating per-hart error counter with sticky permanent-fault flag.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   inc_i          : count one successful recovery of this hart
//   clear_i        : zero the count and the sticky flag (wins over inc_i)
//   count_o        : current count, saturates at all-ones
//   perm_fault_o   : set once a post-increment count reaches PermThreshold
module tmr_err_counter
  import eros_pkg::*;
#(
  parameter int unsigned CntWidth      = 8,
  parameter int unsigned PermThreshold = TMR_PERM_THRESHOLD
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                clear_i,
  output logic [CntWidth-1:0] count_o,
  output logic                perm_fault_o
);

  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [CntWidth-1:0] count_q, count_d;
  logic                perm_q, perm_d;

  always_comb begin
    count_d = count_q;
    perm_d  = perm_q;
    if (clear_i) begin
      count_d = '0;
      perm_d  = 1'b0;
    end else if (inc_i) begin
      if (count_q != CntMax) begin
        count_d = count_q + CntWidth'(1);
      end
      if (32'(count_d) >= PermThreshold) begin
        perm_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      perm_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      perm_q  <= perm_d;
    end
  end

  assign count_o      = count_q;
  assign perm_fault_o = perm_q;

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// TMR recovery controller: classifies voter errors, sequences halt ->
// resynchronise -> resume of the harts, and tracks per-hart error counts.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   enable_i           : TMR mode active; gates acceptance of new errors
//   error_i            : voter error
//   error_id_i         : voter per-hart mismatch vector
//   halt_ack_i         : all harts halted
//   recovery_done_i    : resynchronisation complete
//   clear_i            : leave FATAL, zero counters, sticky flags and faulty set
//   halt_req_o         : halt request to all harts
//   recovery_req_o     : resynchronisation request for the faulty hart
//   faulty_id_o        : one-hot faulty hart, valid with recovery_req_o
//   recovered_o        : one-cycle pulse on successful recovery
//   fatal_o            : uncorrectable fault, held until clear_i
//   perm_fault_o       : sticky per-hart permanent-fault flags
//   err_count_o        : per-hart counts, hart i at [i*CNT_WIDTH +: CNT_WIDTH]
module tmr_recovery_ctrl
  import eros_pkg::*;
#(
  parameter int unsigned NHARTS         = TMR_NHARTS,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned PERM_THRESHOLD = TMR_PERM_THRESHOLD,
  parameter int unsigned TIMEOUT_CYCLES = TMR_TIMEOUT_CYCLES
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          error_i,
  input  logic [NHARTS-1:0]             error_id_i,
  input  logic                          halt_ack_i,
  input  logic                          recovery_done_i,
  input  logic                          clear_i,
  output logic                          halt_req_o,
  output logic                          recovery_req_o,
  output logic [NHARTS-1:0]             faulty_id_o,
  output logic                          recovered_o,
  output logic                          fatal_o,
  output logic [NHARTS-1:0]             perm_fault_o,
  output logic [NHARTS*CNT_WIDTH-1:0]   err_count_o
);

  localparam int unsigned       TimerW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

  tmr_rec_state_e    state_q, state_d;
  logic [NHARTS-1:0] faulty_q, faulty_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              timer_expired;
  logic [NHARTS-1:0] hart_inc;

  assign timer_expired = (timer_q == TimerMax);

  always_comb begin
    state_d  = state_q;
    faulty_d = faulty_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i && error_i) begin
          faulty_d = error_id_i;
          state_d  = (error_id_i != '0 && !tmr_is_multi(error_id_i)) ? StHalt : StFatal;
        end
      end
      StHalt: begin
        // Further mismatches while halting accumulate; a second hart escalates.
        faulty_d = faulty_q | error_id_i;
        if (tmr_is_multi(faulty_d)) begin
          state_d = StFatal;
        end else if (halt_ack_i) begin
          state_d = StRecover;
        end else if (timer_expired) begin
          state_d = StFatal;
        end
      end
      StRecover: begin
        if (recovery_done_i) begin
          state_d = StResume;
        end else if (timer_expired) begin
          state_d = StFatal;
        end
      end
      StResume: begin
        faulty_d = '0;
        state_d  = StIdle;
      end
      StFatal: begin
        if (clear_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear_i) begin
      faulty_d = '0;
    end
  end

  // Timer restarts on every state change and only runs in the waiting states.
  always_comb begin
    timer_d = '0;
    if (state_d == state_q && (state_q == StHalt || state_q == StRecover)) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      faulty_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      faulty_q <= faulty_d;
      timer_q  <= timer_d;
    end
  end

  assign halt_req_o     = (state_q == StHalt) || (state_q == StRecover) || (state_q == StFatal);
  assign recovery_req_o = (state_q == StRecover);
  assign faulty_id_o    = (state_q == StRecover) ? faulty_q : '0;
  assign recovered_o    = (state_q == StResume);
  assign fatal_o        = (state_q == StFatal);

  assign hart_inc = (state_q == StResume) ? faulty_q : '0;

  for (genvar i = 0; i < NHARTS; i++) begin : g_cnt
    tmr_err_counter #(
      .CntWidth      (CNT_WIDTH),
      .PermThreshold (PERM_THRESHOLD)
    ) u_cnt (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .inc_i        (hart_inc[i]),
      .clear_i      (clear_i),
      .count_o      (err_count_o[i*CNT_WIDTH +: CNT_WIDTH]),
      .perm_fault_o (perm_fault_o[i])
    );
  end

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Directed bench for tmr_recovery_ctrl. A second instance with 2-bit counters
// receives identical stimulus to observe counter saturation.
module tb_tmr_recovery_ctrl;

  localparam int unsigned T = 1024;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        enable, error, halt_ack, recovery_done, clear;
  logic [2:0]  error_id;
  logic        halt_req, recovery_req, recovered, fatal;
  logic [2:0]  faulty_id, perm_fault;
  logic [23:0] err_count;
  logic        halt_req2, recovery_req2, recovered2, fatal2;
  logic [2:0]  faulty_id2, perm_fault2;
  logic [5:0]  err_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tmr_recovery_ctrl #(
    .NHARTS(3), .CNT_WIDTH(8), .PERM_THRESHOLD(4), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable), .error_i(error),
    .error_id_i(error_id), .halt_ack_i(halt_ack), .recovery_done_i(recovery_done),
    .clear_i(clear), .halt_req_o(halt_req), .recovery_req_o(recovery_req),
    .faulty_id_o(faulty_id), .recovered_o(recovered), .fatal_o(fatal),
    .perm_fault_o(perm_fault), .err_count_o(err_count)
  );

  tmr_recovery_ctrl #(
    .NHARTS(3), .CNT_WIDTH(2), .PERM_THRESHOLD(4), .TIMEOUT_CYCLES(T)
  ) dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable), .error_i(error),
    .error_id_i(error_id), .halt_ack_i(halt_ack), .recovery_done_i(recovery_done),
    .clear_i(clear), .halt_req_o(halt_req2), .recovery_req_o(recovery_req2),
    .faulty_id_o(faulty_id2), .recovered_o(recovered2), .fatal_o(fatal2),
    .perm_fault_o(perm_fault2), .err_count_o(err_count2)
  );

  // in  = {enable, error, error_id[2:0], halt_ack, recovery_done, clear}
  // exp = {halt_req, recovery_req, faulty_id[2:0], recovered, fatal, perm_fault[2:0]}
  typedef struct {
    logic [7:0] in;
    logic [9:0] exp;
    logic [7:0] cnt1;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  logic [9:0] obs;
  assign obs = {halt_req, recovery_req, faulty_id, recovered, fatal, perm_fault};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic quiet();
    enable = 1'b1; error = 1'b0; error_id = 3'b000;
    halt_ack = 1'b0; recovery_done = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear();
    quiet(); clear = 1'b1; tick(); quiet();
  endtask

  task automatic do_recovery(input logic [2:0] id);
    quiet(); error = 1'b1; error_id = id; tick();
    quiet(); halt_ack = 1'b1; tick();
    quiet(); recovery_done = 1'b1; tick();
    quiet(); tick();
  endtask

  initial begin
    vecs[0]  = '{8'b1_1_010_0_0_0, 10'b1_0_000_0_0_000, 8'd0};
    vecs[1]  = '{8'b1_0_000_0_0_0, 10'b1_0_000_0_0_000, 8'd0};
    vecs[2]  = '{8'b1_0_000_0_0_0, 10'b1_0_000_0_0_000, 8'd0};
    vecs[3]  = '{8'b1_0_000_1_0_0, 10'b1_1_010_0_0_000, 8'd0};
    vecs[4]  = '{8'b1_0_000_0_0_0, 10'b1_1_010_0_0_000, 8'd0};
    vecs[5]  = '{8'b1_0_000_0_0_0, 10'b1_1_010_0_0_000, 8'd0};
    vecs[6]  = '{8'b1_0_000_0_0_0, 10'b1_1_010_0_0_000, 8'd0};
    vecs[7]  = '{8'b1_0_000_0_0_0, 10'b1_1_010_0_0_000, 8'd0};
    vecs[8]  = '{8'b1_0_000_0_1_0, 10'b0_0_000_1_0_000, 8'd0};
    vecs[9]  = '{8'b1_0_000_0_0_0, 10'b0_0_000_0_0_000, 8'd1};
    vecs[10] = '{8'b1_1_011_0_0_0, 10'b1_0_000_0_1_000, 8'd1};
    vecs[11] = '{8'b1_0_000_0_0_0, 10'b1_0_000_0_1_000, 8'd1};
    vecs[12] = '{8'b1_0_000_0_0_1, 10'b0_0_000_0_0_000, 8'd0};
    vecs[13] = '{8'b0_1_010_0_0_0, 10'b0_0_000_0_0_000, 8'd0};
    vecs[14] = '{8'b0_1_011_0_0_0, 10'b0_0_000_0_0_000, 8'd0};
    vecs[15] = '{8'b1_1_000_0_0_0, 10'b1_0_000_0_1_000, 8'd0};
    vecs[16] = '{8'b1_0_000_0_0_1, 10'b0_0_000_0_0_000, 8'd0};

    // Reset
    rst_ni = 1'b0;
    quiet();
    tick(); tick();
    check("reset outs", 32'(obs), 32'(0));
    check("reset counts", 32'(err_count), 32'(0));
    rst_ni = 1'b1;
    tick();

    // Table: single fault, double fault, disabled errors, empty id vector
    for (int i = 0; i < NV; i++) begin
      {enable, error, error_id, halt_ack, recovery_done, clear} = vecs[i].in;
      tick();
      check($sformatf("vec%0d outs", i), 32'(obs), 32'(vecs[i].exp));
      check($sformatf("vec%0d cnt1", i), 32'(err_count[15:8]), 32'(vecs[i].cnt1));
    end
    quiet();

    // Escalation in HALT: second hart reported together with halt_ack
    error = 1'b1; error_id = 3'b001; tick();
    check("esc halt", 32'(obs), 32'(10'b1_0_000_0_0_000));
    quiet(); error = 1'b1; error_id = 3'b100; halt_ack = 1'b1; tick();
    check("esc fatal", 32'(obs), 32'(10'b1_0_000_0_1_000));
    quiet(); tick();
    check("esc hold", 32'(obs), 32'(10'b1_0_000_0_1_000));
    do_clear();
    check("esc clear", 32'(obs), 32'(0));

    // Timeout in HALT
    error = 1'b1; error_id = 3'b001; tick();
    quiet();
    for (int c = 0; c < int'(T) - 1; c++) tick();
    check("halt to pre", 32'({halt_req, fatal}), 32'(2'b10));
    tick();
    check("halt to expiry", 32'({halt_req, fatal}), 32'(2'b11));
    do_clear();

    // Timeout in RECOVER
    error = 1'b1; error_id = 3'b001; tick();
    quiet(); halt_ack = 1'b1; tick();
    quiet();
    for (int c = 0; c < int'(T) - 1; c++) tick();
    check("rec to pre", 32'({recovery_req, fatal}), 32'(2'b10));
    tick();
    check("rec to expiry", 32'({recovery_req, fatal}), 32'(2'b01));
    check("rec to counts", 32'(err_count), 32'(0));
    do_clear();

    // Threshold: four recoveries on hart 0, then saturation on the 2-bit instance
    for (int k = 1; k <= 4; k++) begin
      do_recovery(3'b001);
      check($sformatf("thr cnt0 #%0d", k), 32'(err_count[7:0]), 32'(k));
      check($sformatf("thr perm #%0d", k), 32'(perm_fault), 32'((k == 4) ? 3 'b001 : 3'b000));
    end
    do_recovery(3'b001);
    check("sat cnt0 wide", 32'(err_count[7:0]), 32'(5));
    check("sat cnt0 narrow", 32'(err_count2[1:0]), 32'(3));
    check("sat perm narrow", 32'(perm_fault2), 32'(0));
    check("sat perm wide", 32'(perm_fault), 32'(3'b001));

    // Asynchronous reset mid-RECOVER
    error = 1'b1; error_id = 3'b010; tick();
    quiet(); halt_ack = 1'b1; tick();
    quiet();
    check("pre-rst rec", 32'({recovery_req, faulty_id}), 32'(4'b1_010));
    #2 rst_ni = 1'b0;
    #1;
    check("async rst outs", 32'(obs), 32'(0));
    check("async rst counts", 32'(err_count), 32'(0));
    #1 rst_ni = 1'b1;
    tick();
    check("post-rst idle", 32'(obs), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
